onehot_to_priority_collector: RTL and testbench
===============================================

ONEHOT_TO_PRIORITY_COLLECTOR -- requirements
Module: onehot_to_priority_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 32, vector width in bits (WIDTH >= 2).
REQ-002 SHALL have localparam WIDTH_LOG = $clog2(WIDTH), index width.
REQ-003 SHALL have parameter IMPLEMENTATION, default 0, one-hot check style: 0 = adder (x & (x-1)), 1 = loop; both functionally identical.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_vld  input  1  input beat valid.
REQ-007 SHALL have port in_rdy  output  1  input beat ready.
REQ-008 SHALL have port in_oht  input  WIDTH  one-hot token, expected exactly one bit set.
REQ-009 SHALL have port in_lst  input  1  last beat of frame.
REQ-010 SHALL have port out_vld  output  1  collected frame valid.
REQ-011 SHALL have port out_rdy  input  1  collected frame ready.
REQ-012 SHALL have port out_pry  output  WIDTH  OR of all tokens in frame (priority vector).
REQ-013 SHALL have port out_cnt  output  WIDTH_LOG+1  number of beats accepted in frame, saturating.
REQ-014 SHALL have port out_err  output  1  frame contained at least one illegal beat.

Function
REQ-015 SHALL implement two states: COLLECT and HOLD.
REQ-016 In COLLECT: in_rdy = 1, out_vld = 0; in HOLD: in_rdy = 0, out_vld = 1; both outputs decoded from registered state only.
REQ-017 Input transfer occurs on cycle with in_vld & in_rdy; output transfer on out_vld & out_rdy.
REQ-018 On input transfer: accumulator <= accumulator | in_oht; count <= count+1, saturating at 2^(WIDTH_LOG+1)-1.
REQ-019 Beat illegal if in_oht == 0, more than one bit set, or (in_oht & accumulator) != 0 (duplicate); illegal beat sets sticky frame error, still ORed into accumulator and counted.
REQ-020 Input transfer with in_lst = 1 SHALL move COLLECT -> HOLD; out_vld asserted the next cycle (latency 1 cycle from last beat).
REQ-021 In HOLD out_pry, out_cnt, out_err SHALL remain stable until output transfer.
REQ-022 Output transfer SHALL move HOLD -> COLLECT and clear accumulator, count, error in the same edge; next frame accepted on the following cycle.
REQ-023 in_vld/in_oht/in_lst SHALL be ignored in HOLD (no bypass; in_rdy low).
REQ-024 out_rdy SHALL be ignored in COLLECT.
REQ-025 Single-beat frame (in_lst on first beat) SHALL be legal: out_cnt = 1.
REQ-026 Frame filling all WIDTH bits with legal beats SHALL yield out_pry = all ones, out_cnt = WIDTH, out_err = 0.
REQ-027 out_pry, out_cnt, out_err SHALL read zero in COLLECT (accumulating values internal only).

Reset
REQ-028 rst = 1 on a clock edge SHALL force state COLLECT, accumulator 0, count 0, error 0, regardless of state or handshakes that cycle.
REQ-029 After reset: in_rdy = 1, out_vld = 0, out_pry = 0, out_cnt = 0, out_err = 0.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial/held frame with no output transfer.

Verification
REQ-031 WIDTH=8: beats 0x01, 0x04, 0x80(lst) -> next cycle out_vld=1, out_pry=0x85, out_cnt=3, out_err=0.
REQ-032 WIDTH=8: beats 0x02, 0x02(lst) -> out_pry=0x02, out_cnt=2, out_err=1 (duplicate); beat 0x00(lst) or 0x03(lst) alone -> out_err=1.
REQ-033 Hold out_rdy=0 for 5 cycles in HOLD with in_vld=1 -> in_rdy=0, outputs stable, no beat accepted; then out_rdy=1 -> COLLECT, outputs zero next cycle.
REQ-034 WIDTH=8: 8 legal beats 0x01..0x80 -> out_pry=0xFF, out_cnt=8, out_err=0; 20-beat frame -> out_cnt=15 (saturated), out_err=1.
REQ-035 Assert rst for 1 cycle after 2 beats of a frame -> outputs all zero, next frame 0x10(lst) -> out_pry=0x10, out_cnt=1.
REQ-036 Run identical random stimulus with IMPLEMENTATION=0 and 1 -> cycle-identical outputs.

Source files
------------

// File: rtl/onehot_to_priority_collector.sv
// onehot_to_priority_collector
// Gathers a frame of one-hot tokens into a single priority vector. Each
// accepted beat is ORed into an accumulator and counted; malformed or
// duplicate tokens raise a sticky frame error. When the last beat arrives
// the collected frame is held on the output side until it is taken, and
// the input side stays closed meanwhile.
module onehot_to_priority_collector #(
    parameter  int WIDTH          = 32,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [WIDTH-1:0]     in_oht,
    input  logic                 in_lst,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [WIDTH-1:0]     out_pry,
    output logic [WIDTH_LOG:0]   out_cnt,
    output logic                 out_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [WIDTH_LOG:0] CNT_ONE = (WIDTH_LOG + 1)'(1);
    localparam logic [WIDTH_LOG:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH_LOG:0]     cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   is_onehot;
    logic                   is_dup;
    logic                   beat_bad;

    // Exactly-one-bit test using the x & (x-1) trick: clears the lowest set bit.
    function automatic logic onehot_adder(input logic [WIDTH-1:0] x);
        return (x != '0) && ((x & (x - ONE_W)) == '0);
    endfunction

    // Exactly-one-bit test by counting set bits one at a time.
    function automatic logic onehot_loop(input logic [WIDTH-1:0] x);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) n++;
        end
        return (n == 1);
    endfunction

    // Beat counter increment that sticks at the top of its range.
    function automatic logic [WIDTH_LOG:0] sat_inc(input logic [WIDTH_LOG:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    generate
        if (IMPLEMENTATION == 1) begin : g_oh_loop
            assign is_onehot = onehot_loop(in_oht);
        end else begin : g_oh_adder
            assign is_onehot = onehot_adder(in_oht);
        end
    endgenerate

    // A token already present in the frame counts as illegal too.
    assign is_dup   = |(in_oht & acc_q);
    assign beat_bad = !is_onehot || is_dup;

    // Handshakes come straight from the registered state.
    assign in_rdy  = (state_q == COLLECT);
    assign out_vld = (state_q == HOLD);

    // Accumulated values stay hidden until the frame is complete.
    assign out_pry = out_vld ? acc_q : '0;
    assign out_cnt = out_vld ? cnt_q : '0;
    assign out_err = out_vld ? err_q : 1'b0;

    // Next-state and accumulator update for both handshake sides.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (in_vld) begin
                    acc_d = acc_q | in_oht;
                    cnt_d = sat_inc(cnt_q);
                    err_d = err_q | beat_bad;
                    if (in_lst) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and frame registers; reset discards any partial or held frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_onehot_to_priority_collector.sv
// Bench for onehot_to_priority_collector (WIDTH=8), both check styles side by side.
module tb_onehot_to_priority_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld, in_lst, out_rdy;
    logic [W-1:0] in_oht;

    logic         in_rdy, out_vld, out_err;
    logic [W-1:0] out_pry;
    logic [3:0]   out_cnt;

    logic         in_rdy_1, out_vld_1, out_err_1;
    logic [W-1:0] out_pry_1;
    logic [3:0]   out_cnt_1;

    typedef struct packed {
        logic [W-1:0] pry;
        logic [3:0]   cnt;
        logic         err;
    } frame_t;

    frame_t       exp_q[$];
    logic [W-1:0] m_acc;
    logic [3:0]   m_cnt;
    logic         m_err;
    logic         m_hold;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onehot_to_priority_collector #(.WIDTH(W), .IMPLEMENTATION(0)) u0 (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_oht(in_oht), .in_lst(in_lst),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_pry(out_pry), .out_cnt(out_cnt), .out_err(out_err)
    );

    onehot_to_priority_collector #(.WIDTH(W), .IMPLEMENTATION(1)) u1 (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy_1), .in_oht(in_oht), .in_lst(in_lst),
        .out_vld(out_vld_1), .out_rdy(out_rdy),
        .out_pry(out_pry_1), .out_cnt(out_cnt_1), .out_err(out_err_1)
    );

    task automatic model_clear();
        m_acc  = '0;
        m_cnt  = '0;
        m_err  = 1'b0;
        m_hold = 1'b0;
    endtask

    task automatic model_beat(input logic [W-1:0] x, input logic l);
        frame_t f;
        if (x == '0 || $countones(x) != 1 || (x & m_acc) != '0) m_err = 1'b1;
        m_acc = m_acc | x;
        if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        if (l) begin
            f = '{pry: m_acc, cnt: m_cnt, err: m_err};
            exp_q.push_back(f);
        end
    endtask

    task automatic drive_beat(input logic [W-1:0] x, input logic l);
        @(negedge clk);
        in_vld = 1'b1;
        in_oht = x;
        in_lst = l;
        model_beat(x, l);
        @(posedge clk);
    endtask

    // Wait (bounded) for a frame on the output side; returns extra cycles beyond 1.
    task automatic wait_out(output frame_t got, output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_vld && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (out_vld !== 1'b1) begin
            bad++;
            $display("FAIL out_vld_timeout got=%b want=1", out_vld);
        end
        got = {out_pry, out_cnt, out_err};
    endtask

    task automatic release_frame();
        out_rdy = 1'b1;
        in_vld  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_rdy = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; in_oht = '0; in_lst = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        total++;
        if ({in_rdy, out_vld, out_pry, out_cnt, out_err} !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b pry=%h cnt=%0d err=%b want rdy=1 vld=0 zeros",
                     in_rdy, out_vld, out_pry, out_cnt, out_err);
        end
    endtask

    task automatic test_basic();
        frame_t got, e;
        int lat;
        drive_beat(8'h01, 1'b0);
        drive_beat(8'h04, 1'b0);
        drive_beat(8'h80, 1'b1);
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL basic_latency got=%0d extra cycles want=0", lat);
        end
        total++;
        if (got !== e || got !== {8'h85, 4'd3, 1'b0}) begin
            bad++;
            $display("FAIL basic_frame got pry=%h cnt=%0d err=%b want pry=85 cnt=3 err=0",
                     got.pry, got.cnt, got.err);
        end
        release_frame();
        total++;
        if ({in_rdy, out_vld, out_pry, out_cnt, out_err} !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL basic_after_release got rdy=%b vld=%b pry=%h cnt=%0d err=%b want rdy=1 vld=0 zeros",
                     in_rdy, out_vld, out_pry, out_cnt, out_err);
        end
    endtask

    task automatic test_errors();
        logic [W-1:0] beats[4] = '{8'h02, 8'h02, 8'h00, 8'h03};
        logic         lsts[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        frame_t got, e;
        int lat;
        for (int i = 0; i < 4; i++) begin
            drive_beat(beats[i], lsts[i]);
            if (lsts[i]) begin
                wait_out(got, lat);
                e = exp_q.pop_front();
                total++;
                if (got !== e || got.err !== 1'b1) begin
                    bad++;
                    $display("FAIL error_frame%0d got pry=%h cnt=%0d err=%b want pry=%h cnt=%0d err=1",
                             i, got.pry, got.cnt, got.err, e.pry, e.cnt);
                end
                release_frame();
            end
        end
    endtask

    task automatic test_hold_stall();
        frame_t got, e;
        int lat;
        drive_beat(8'h08, 1'b1);
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL stall_frame got pry=%h cnt=%0d err=%b want pry=%h cnt=%0d err=%b",
                     got.pry, got.cnt, got.err, e.pry, e.cnt, e.err);
        end
        for (int c = 0; c < 5; c++) begin
            in_vld = 1'b1; in_oht = 8'h40; in_lst = 1'b1; out_rdy = 1'b0;
            @(posedge clk);
            @(negedge clk);
            total++;
            if (in_rdy !== 1'b0 || out_vld !== 1'b1 || {out_pry, out_cnt, out_err} !== e) begin
                bad++;
                $display("FAIL stall_cycle%0d got rdy=%b vld=%b pry=%h cnt=%0d err=%b want rdy=0 vld=1 pry=%h cnt=%0d err=%b",
                         c, in_rdy, out_vld, out_pry, out_cnt, out_err, e.pry, e.cnt, e.err);
            end
        end
        release_frame();
        total++;
        if ({in_rdy, out_vld, out_pry, out_cnt, out_err} !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL stall_release got rdy=%b vld=%b pry=%h cnt=%0d err=%b want rdy=1 vld=0 zeros",
                     in_rdy, out_vld, out_pry, out_cnt, out_err);
        end
        drive_beat(8'h20, 1'b1);
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (got !== e || got !== {8'h20, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL stall_next got pry=%h cnt=%0d err=%b want pry=20 cnt=1 err=0",
                     got.pry, got.cnt, got.err);
        end
        release_frame();
    endtask

    task automatic test_full_and_saturate();
        frame_t got, e;
        int lat;
        for (int i = 0; i < 8; i++) drive_beat(8'(1 << i), (i == 7));
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (got !== e || got !== {8'hFF, 4'd8, 1'b0}) begin
            bad++;
            $display("FAIL full_frame got pry=%h cnt=%0d err=%b want pry=ff cnt=8 err=0",
                     got.pry, got.cnt, got.err);
        end
        release_frame();
        for (int i = 0; i < 20; i++) drive_beat(8'(1 << (i % 8)), (i == 19));
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (got !== e || got !== {8'hFF, 4'd15, 1'b1}) begin
            bad++;
            $display("FAIL saturate_frame got pry=%h cnt=%0d err=%b want pry=ff cnt=15 err=1",
                     got.pry, got.cnt, got.err);
        end
        release_frame();
    endtask

    task automatic test_reset_mid();
        frame_t got, e;
        int lat;
        drive_beat(8'h01, 1'b0);
        drive_beat(8'h02, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        total++;
        if ({in_rdy, out_vld, out_pry, out_cnt, out_err} !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL midframe_reset got rdy=%b vld=%b pry=%h cnt=%0d err=%b want rdy=1 vld=0 zeros",
                     in_rdy, out_vld, out_pry, out_cnt, out_err);
        end
        drive_beat(8'h10, 1'b1);
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (got !== e || got !== {8'h10, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_midreset got pry=%h cnt=%0d err=%b want pry=10 cnt=1 err=0",
                     got.pry, got.cnt, got.err);
        end
        // Reset while holding: the frame is dropped without a transfer.
        rst = 1'b1; in_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        total++;
        if ({in_rdy, out_vld, out_pry, out_cnt, out_err} !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL hold_reset got rdy=%b vld=%b pry=%h cnt=%0d err=%b want rdy=1 vld=0 zeros",
                     in_rdy, out_vld, out_pry, out_cnt, out_err);
        end
        drive_beat(8'h40, 1'b1);
        wait_out(got, lat);
        e = exp_q.pop_front();
        total++;
        if (got !== e || got !== {8'h40, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_holdreset got pry=%h cnt=%0d err=%b want pry=40 cnt=1 err=0",
                     got.pry, got.cnt, got.err);
        end
        release_frame();
    endtask

    task automatic test_random();
        frame_t e;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            total++;
            if ({in_rdy, out_vld, out_pry, out_cnt, out_err} !==
                {in_rdy_1, out_vld_1, out_pry_1, out_cnt_1, out_err_1}) begin
                bad++;
                $display("FAIL impl_diff cyc=%0d got0 pry=%h cnt=%0d err=%b got1 pry=%h cnt=%0d err=%b",
                         c, out_pry, out_cnt, out_err, out_pry_1, out_cnt_1, out_err_1);
            end
            total++;
            if (in_rdy !== !m_hold || out_vld !== m_hold) begin
                bad++;
                $display("FAIL rand_handshake cyc=%0d got rdy=%b vld=%b want rdy=%b vld=%b",
                         c, in_rdy, out_vld, !m_hold, m_hold);
            end
            if (!m_hold) begin
                total++;
                if ({out_pry, out_cnt, out_err} !== 13'd0) begin
                    bad++;
                    $display("FAIL rand_idle_zero cyc=%0d got pry=%h cnt=%0d err=%b want zeros",
                             c, out_pry, out_cnt, out_err);
                end
            end
            in_vld  = ($urandom_range(0, 3) != 0);
            in_oht  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            in_lst  = ($urandom_range(0, 3) == 0);
            out_rdy = ($urandom_range(0, 1) == 1);
            if (m_hold && out_rdy) begin
                e = exp_q.pop_front();
                total++;
                if ({out_pry, out_cnt, out_err} !== e) begin
                    bad++;
                    $display("FAIL rand_frame cyc=%0d got pry=%h cnt=%0d err=%b want pry=%h cnt=%0d err=%b",
                             c, out_pry, out_cnt, out_err, e.pry, e.cnt, e.err);
                end
                model_clear();
            end else if (!m_hold && in_vld) begin
                model_beat(in_oht, in_lst);
                if (in_lst) m_hold = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        out_rdy = 1'b0;
        exp_q.delete();
        model_clear();
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_oht = '0; in_lst = 1'b0; out_rdy = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_errors();
        test_hold_stall();
        test_full_and_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
